// File: rtl/noc_params.sv
// Shared NoC parameters: default flit/VC shape, the default link stage depth,
// the checker state encoding and a helper for VC index width.
package noc_params;

    localparam int NOC_FLIT_W          = 32;
    localparam int NOC_VC_NUM          = 2;
    localparam int LINK_STAGES_DEFAULT = 2;

    typedef logic [NOC_FLIT_W-1:0] flit_t;

    // On/off checker state: mirrors the on/off bit currently visible upstream.
    typedef enum logic {
        CHK_OFF = 1'b0,
        CHK_ON  = 1'b1
    } chk_state_e;

    // Width of a VC index; a single VC still gets a 1-bit field.
    function automatic int vc_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/link_onoff_checker.sv
// Per-VC on/off protocol checker. Counts flits that arrive while "off" is
// visible upstream and flags (sticky) more than SLACK_MAX of them.
// The state register is fed with the next value of the upstream-facing on/off
// register, so it always equals the on/off bit upstream sees this cycle and a
// flit is judged against the pre-edge value.
module link_onoff_checker
    import noc_params::*;
#(
    parameter int SLACK_MAX = 4,
    localparam int CNT_W    = $clog2(SLACK_MAX + 2)
) (
    input  logic clk,
    input  logic rst,
    input  logic on_off_next,
    input  logic flit,
    input  logic bad_flit,
    output logic error
);

    chk_state_e       state_q;
    chk_state_e       state_d;
    logic [CNT_W-1:0] slack_q;
    logic [CNT_W-1:0] slack_d;
    logic             err_d;

    // State register: starts OFF, matching the reset value of the on/off path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= CHK_OFF;
        else      state_q <= state_d;
    end

    // Next state simply follows the upstream-facing on/off bit.
    always_comb begin
        state_d = on_off_next ? CHK_ON : CHK_OFF;
    end

    // Slack counting and sticky error decision for the current state.
    always_comb begin
        slack_d = slack_q;
        err_d   = error | bad_flit;
        case (state_q)
            CHK_ON: slack_d = '0;
            CHK_OFF: begin
                if (flit) begin
                    if (slack_q >= CNT_W'(SLACK_MAX)) err_d = 1'b1;
                    if (slack_q != CNT_W'(SLACK_MAX + 1)) slack_d = slack_q + 1'b1;
                end
            end
            default: slack_d = slack_q;
        endcase
    end

    // Counter and error registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slack_q <= '0;
            error   <= 1'b0;
        end else begin
            slack_q <= slack_d;
            error   <= err_d;
        end
    end

endmodule

// File: rtl/router_link_stage.sv
// Pipelined router-to-router link: STAGES registers forward for flits and
// STAGES registers backward for per-VC on/off and allocatable status.
// No backpressure: flits are never stalled, dropped or reordered.
// Optional feature: define ROUTER_LINK_CHECK_EN to build the per-VC on/off
// slack checker; otherwise error_o is tied to 0.
module router_link_stage
    import noc_params::*;
#(
    parameter int FLIT_W    = $bits(flit_t),
    parameter int VC_NUM    = NOC_VC_NUM,
    parameter int STAGES    = LINK_STAGES_DEFAULT,
    parameter int SLACK_MAX = 2 * STAGES,
    localparam int VC_W     = vc_width(VC_NUM),
    localparam int CNT_W    = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] up_data_i,
    input  logic              up_valid_i,
    input  logic [VC_W-1:0]   up_vc_i,
    output logic [FLIT_W-1:0] down_data_o,
    output logic              down_valid_o,
    output logic [VC_W-1:0]   down_vc_o,
    input  logic [VC_NUM-1:0] down_on_off_i,
    input  logic [VC_NUM-1:0] down_alloc_i,
    output logic [VC_NUM-1:0] up_on_off_o,
    output logic [VC_NUM-1:0] up_alloc_o,
    output logic [CNT_W-1:0]  inflight_o,
    output logic [VC_NUM-1:0] error_o
);

    logic [STAGES-1:0] fwd_valid_q;
    logic [STAGES-1:0] valid_next;
    logic [FLIT_W-1:0] fwd_data_q [STAGES];
    logic [VC_W-1:0]   fwd_vc_q   [STAGES];
    logic [CNT_W-1:0]  inflight_d;

    logic [VC_NUM-1:0] rev_on_q    [STAGES];
    logic [VC_NUM-1:0] rev_on_d    [STAGES];
    logic [VC_NUM-1:0] rev_alloc_q [STAGES];
    logic [VC_NUM-1:0] rev_alloc_d [STAGES];

    // Next valid vector of the forward pipe and its population count.
    always_comb begin
        valid_next    = '0;
        inflight_d    = '0;
        valid_next[0] = up_valid_i;
        for (int s = 1; s < STAGES; s++) valid_next[s] = fwd_valid_q[s-1];
        for (int s = 0; s < STAGES; s++) inflight_d = inflight_d + CNT_W'(valid_next[s]);
    end

    // Forward pipe: data/vc load only behind a valid flit, bubbles clear valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_valid_q <= '0;
            inflight_o  <= '0;
            for (int s = 0; s < STAGES; s++) begin
                fwd_data_q[s] <= '0;
                fwd_vc_q[s]   <= '0;
            end
        end else begin
            fwd_valid_q <= valid_next;
            inflight_o  <= inflight_d;
            if (up_valid_i) begin
                fwd_data_q[0] <= up_data_i;
                fwd_vc_q[0]   <= up_vc_i;
            end
            for (int s = 1; s < STAGES; s++) begin
                if (fwd_valid_q[s-1]) begin
                    fwd_data_q[s] <= fwd_data_q[s-1];
                    fwd_vc_q[s]   <= fwd_vc_q[s-1];
                end
            end
        end
    end

    assign down_valid_o = fwd_valid_q[STAGES-1];
    assign down_data_o  = fwd_data_q[STAGES-1];
    assign down_vc_o    = fwd_vc_q[STAGES-1];

    // Next values of the reverse status pipe.
    always_comb begin
        rev_on_d[0]    = down_on_off_i;
        rev_alloc_d[0] = down_alloc_i;
        for (int s = 1; s < STAGES; s++) begin
            rev_on_d[s]    = rev_on_q[s-1];
            rev_alloc_d[s] = rev_alloc_q[s-1];
        end
    end

    // Reverse status pipe: resets to off / not allocatable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < STAGES; s++) begin
                rev_on_q[s]    <= '0;
                rev_alloc_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                rev_on_q[s]    <= rev_on_d[s];
                rev_alloc_q[s] <= rev_alloc_d[s];
            end
        end
    end

    assign up_on_off_o = rev_on_q[STAGES-1];
    assign up_alloc_o  = rev_alloc_q[STAGES-1];

`ifdef ROUTER_LINK_CHECK_EN
    logic bad_vc;

    // A VC index outside the configured range is reported on VC 0.
    assign bad_vc = up_valid_i && ({{(32-VC_W){1'b0}}, up_vc_i} >= VC_NUM);

    for (genvar v = 0; v < VC_NUM; v++) begin : g_chk
        link_onoff_checker #(
            .SLACK_MAX (SLACK_MAX)
        ) u_chk (
            .clk         (clk),
            .rst         (rst),
            .on_off_next (rev_on_d[STAGES-1][v]),
            .flit        (up_valid_i && ({{(32-VC_W){1'b0}}, up_vc_i} == v)),
            .bad_flit    ((v == 0) ? bad_vc : 1'b0),
            .error       (error_o[v])
        );
    end
`else
    assign error_o = '0;
`endif

endmodule

// File: tb/tb_router_link_stage.sv
// Bench for router_link_stage (default parameters: FLIT_W=32, VC_NUM=2, STAGES=2).
// A cycle-indexed log of accepted inputs predicts every output; directed
// sequences add hand-computed literal expectations.
module tb_router_link_stage;

    localparam int FLIT_W    = 32;
    localparam int VC_NUM    = 2;
    localparam int STAGES    = 2;
    localparam int SLACK_MAX = 2 * STAGES;
    localparam int VC_W      = 1;
    localparam int CNT_W     = 2;
    localparam int LOG_N     = 4096;
`ifdef ROUTER_LINK_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [FLIT_W-1:0] up_data_i;
    logic              up_valid_i;
    logic [VC_W-1:0]   up_vc_i;
    logic [FLIT_W-1:0] down_data_o;
    logic              down_valid_o;
    logic [VC_W-1:0]   down_vc_o;
    logic [VC_NUM-1:0] down_on_off_i;
    logic [VC_NUM-1:0] down_alloc_i;
    logic [VC_NUM-1:0] up_on_off_o;
    logic [VC_NUM-1:0] up_alloc_o;
    logic [CNT_W-1:0]  inflight_o;
    logic [VC_NUM-1:0] error_o;

    always #5 clk = ~clk;

    router_link_stage dut (
        .clk           (clk),
        .rst           (rst),
        .up_data_i     (up_data_i),
        .up_valid_i    (up_valid_i),
        .up_vc_i       (up_vc_i),
        .down_data_o   (down_data_o),
        .down_valid_o  (down_valid_o),
        .down_vc_o     (down_vc_o),
        .down_on_off_i (down_on_off_i),
        .down_alloc_i  (down_alloc_i),
        .up_on_off_o   (up_on_off_o),
        .up_alloc_o    (up_alloc_o),
        .inflight_o    (inflight_o),
        .error_o       (error_o)
    );

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Every edge with reset released logs the inputs it samples. The output
    // after edge c is the flit logged STAGES-1 edges earlier; anything logged
    // at or before the last reset mark never existed.
    logic              lg_valid [LOG_N];
    logic [FLIT_W-1:0] lg_data  [LOG_N];
    logic [VC_W-1:0]   lg_vc    [LOG_N];
    logic [VC_NUM-1:0] lg_on    [LOG_N];
    logic [VC_NUM-1:0] lg_alloc [LOG_N];
    int                cyc  = 0;
    int                mark = 0;
    int                slack [VC_NUM];
    logic [VC_NUM-1:0] m_err = '0;

    function automatic bit live(input int k);
        return (k > 0) && (k > mark);
    endfunction

    function automatic logic [VC_NUM-1:0] exp_on();
        int k;
        k = cyc - STAGES + 1;
        return live(k) ? lg_on[k] : '0;
    endfunction

    function automatic logic [VC_NUM-1:0] exp_alloc();
        int k;
        k = cyc - STAGES + 1;
        return live(k) ? lg_alloc[k] : '0;
    endfunction

    always @(negedge rst) begin
        mark  = cyc;
        m_err = '0;
        for (int v = 0; v < VC_NUM; v++) slack[v] = 0;
    end

    always @(posedge clk) begin
        logic [VC_NUM-1:0] pre;
        pre = exp_on();
        if (rst) begin
            if (up_valid_i && int'(up_vc_i) >= VC_NUM) m_err[0] = 1'b1;
            for (int v = 0; v < VC_NUM; v++) begin
                if (pre[v]) slack[v] = 0;
                else if (up_valid_i && int'(up_vc_i) == v) begin
                    if (slack[v] >= SLACK_MAX) m_err[v] = 1'b1;
                    if (slack[v] < SLACK_MAX + 1) slack[v] = slack[v] + 1;
                end
            end
        end
        cyc = cyc + 1;
        if (!rst) mark = cyc;
        lg_valid[cyc] = up_valid_i;
        lg_data[cyc]  = up_data_i;
        lg_vc[cyc]    = up_vc_i;
        lg_on[cyc]    = down_on_off_i;
        lg_alloc[cyc] = down_alloc_i;
    end

    // Compare process: every cycle, mid-period.
    always @(negedge clk) begin
        int  k;
        int  n;
        bit  ev;
        k  = cyc - STAGES + 1;
        ev = live(k) && lg_valid[k];
        check("down_valid", down_valid_o, ev);
        if (ev) begin
            check("down_data", down_data_o, lg_data[k]);
            check("down_vc", down_vc_o, lg_vc[k]);
        end
        n = 0;
        for (int j = 0; j < STAGES; j++)
            if (live(cyc - j) && lg_valid[cyc - j]) n++;
        check("inflight", inflight_o, n);
        check("up_on_off", up_on_off_o, exp_on());
        check("up_alloc", up_alloc_o, exp_alloc());
        check("error", error_o, CHECK_EN ? m_err : '0);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [FLIT_W-1:0] d, input logic [VC_W-1:0] vc);
        up_valid_i = 1'b1;
        up_data_i  = d;
        up_vc_i    = vc;
    endtask

    task automatic idle();
        up_valid_i = 1'b0;
        up_data_i  = '0;
        up_vc_i    = '0;
    endtask

    // ---------------- directed sequences ----------------
    logic [FLIT_W-1:0] tab_d [6];
    logic              tab_v [6];
    logic              obs_v [6];
    logic [FLIT_W-1:0] obs_d [6];
    int                max_inflight;
    int                late_valid;

    initial begin
        idle();
        down_on_off_i = '1;
        down_alloc_i  = '1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_down_valid", down_valid_o, 1'b0);
        check("reset_inflight", inflight_o, 2'd0);
        check("reset_up_on_off", up_on_off_o, 2'b00);
        check("reset_up_alloc", up_alloc_o, 2'b00);
        check("reset_error", error_o, 2'b00);
        rst = 1'b1;
        repeat (STAGES + 1) tick();
        check("status_after_release", up_on_off_o, 2'b11);

        // Single flit 0xA5 on vc1, latency STAGES.
        send(32'hA5, 1'b1);
        tick();
        idle();
        @(negedge clk);
        check("lat_inflight_mid", inflight_o, 2'd1);
        check("lat_valid_early", down_valid_o, 1'b0);
        tick();
        @(negedge clk);
        check("lat_valid", down_valid_o, 1'b1);
        check("lat_data", down_data_o, 32'hA5);
        check("lat_vc", down_vc_o, 1'b1);
        check("lat_inflight_out", inflight_o, 2'd1);
        repeat (3) tick();

        // Flits 1,2,bubble,3 in order.
        tab_v[0] = 1'b1; tab_d[0] = 32'd1;
        tab_v[1] = 1'b1; tab_d[1] = 32'd2;
        tab_v[2] = 1'b0; tab_d[2] = 32'd0;
        tab_v[3] = 1'b1; tab_d[3] = 32'd3;
        tab_v[4] = 1'b0; tab_d[4] = 32'd0;
        tab_v[5] = 1'b0; tab_d[5] = 32'd0;
        max_inflight = 0;
        for (int i = 0; i < 6; i++) begin
            if (tab_v[i]) send(tab_d[i], 1'b0);
            else idle();
            tick();
            @(negedge clk);
            obs_v[i] = down_valid_o;
            obs_d[i] = down_data_o;
            if (int'(inflight_o) > max_inflight) max_inflight = int'(inflight_o);
        end
        idle();
        check("seq_v0", obs_v[1], 1'b1);
        check("seq_d0", obs_d[1], 32'd1);
        check("seq_v1", obs_v[2], 1'b1);
        check("seq_d1", obs_d[2], 32'd2);
        check("seq_bubble", obs_v[3], 1'b0);
        check("seq_v3", obs_v[4], 1'b1);
        check("seq_d3", obs_d[4], 32'd3);
        check("seq_inflight_max", max_inflight <= 2, 1'b1);
        repeat (3) tick();

        // Reverse path: on/off and alloc of vc0 drop, visible STAGES edges later.
        down_on_off_i = 2'b10;
        down_alloc_i  = 2'b10;
        tick();
        @(negedge clk);
        check("rev_on_early", up_on_off_o, 2'b11);
        check("rev_alloc_early", up_alloc_o, 2'b11);
        tick();
        @(negedge clk);
        check("rev_on", up_on_off_o, 2'b10);
        check("rev_alloc", up_alloc_o, 2'b10);
        down_on_off_i = 2'b11;
        down_alloc_i  = 2'b11;
        repeat (STAGES + 1) tick();

        // On/off toggling with 3 off-flits per interval: never an error.
        for (int r = 0; r < 3; r++) begin
            down_on_off_i[0] = 1'b0;
            repeat (STAGES + 1) tick();
            for (int f = 0; f < 3; f++) begin
                send(32'h100 + 32'(r * 4 + f), 1'b0);
                tick();
            end
            idle();
            down_on_off_i[0] = 1'b1;
            repeat (STAGES + 1) tick();
        end
        check("toggle_no_error", error_o, 2'b00);

        // Slack overrun: 4 off-flits tolerated, 5th flags vc0, error sticks.
        down_on_off_i[0] = 1'b0;
        repeat (STAGES + 1) tick();
        for (int f = 0; f < 4; f++) begin
            send(32'h200 + 32'(f), 1'b0);
            tick();
        end
        idle();
        @(negedge clk);
        check("slack4_no_error", error_o, 2'b00);
        send(32'h2FF, 1'b0);
        tick();
        idle();
        @(negedge clk);
        check("slack5_error", error_o, CHECK_EN ? 2'b01 : 2'b00);
        down_on_off_i[0] = 1'b1;
        repeat (4) tick();
        check("slack_error_sticky", error_o, CHECK_EN ? 2'b01 : 2'b00);

        // Reset with two flits in flight: outputs clear at once, nothing emerges.
        send(32'hC1, 1'b1);
        tick();
        send(32'hC2, 1'b0);
        tick();
        idle();
        #1 rst = 1'b0;
        #1;
        check("rst_down_valid", down_valid_o, 1'b0);
        check("rst_inflight", inflight_o, 2'd0);
        check("rst_up_on_off", up_on_off_o, 2'b00);
        check("rst_up_alloc", up_alloc_o, 2'b00);
        check("rst_error", error_o, 2'b00);
        repeat (2) tick();
        rst = 1'b1;
        late_valid = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            if (down_valid_o) late_valid++;
        end
        check("rst_no_residual", late_valid, 0);
        check("rst_status_back", up_on_off_o, 2'b11);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
